dbus_bridge: RTL and testbench
==============================

// Module: dbus_bridge
// PURPOSE
//  Parametrised data-bus bridge between the MEM stage and data RAM plus on-chip I/O.
//  Replaces hard-wired switch/LED handling in the MEM stage with an address-decoded MMIO block.
//  Supports RAM wait states and raises a stall request to ctrl while an access is in flight.
//  Adds byte enables and an optional cycle counter.
// PARAMETERS
//  DATA_W      32            data bus width (multiple of 8)
//  ADDR_W      32            address width
//  RAM_WAIT    1             extra RAM cycles per access; 0 = single-cycle, no stall
//  IO_BASE     32'hBFD0_0000 base of 4 KB MMIO window; addr[ADDR_W-1:12]==IO_BASE[ADDR_W-1:12] selects I/O
//  SW_W        12            switch input width (<= DATA_W)
//  LED_W       32            LED output width (<= DATA_W)
//  SYNC_STAGES 2             switch synchroniser depth (>= 2)
// PORTS
//  clk          in   1          system clock
//  rst          in   1          asynchronous reset, active-low
//  req_i        in   1          MEM stage access valid; held high while stalled
//  we_i         in   1          1 = write, 0 = read
//  addr_i       in   ADDR_W     byte address (word-aligned)
//  sel_i        in   DATA_W/8   byte enables
//  wdata_i      in   DATA_W     write data
//  rdata_o      out  DATA_W     read data to MEM stage
//  stallreq_o   out  1          stall request to ctrl
//  ram_ce_o     out  1          RAM chip enable
//  ram_we_o     out  1          RAM write enable
//  ram_sel_o    out  DATA_W/8   RAM byte enables
//  ram_addr_o   out  ADDR_W     RAM address
//  ram_data_o   out  DATA_W     RAM write data
//  ram_data_i   in   DATA_W     RAM read data
//  switch_on    in   SW_W       asynchronous switch inputs
//  led_out      out  LED_W      LED register
// BEHAVIOUR
//  Reset (rst=0, async): FSM=IDLE, wait counter=0, led_out=0, sync flops=0, cycle counter=0,
//   rdata_o=0, stallreq_o=0, ram_ce_o=0, ram_we_o=0, ram_sel_o=0. Reset mid-access aborts it; no RAM write completes.
//  Decode: io_hit = req_i & window match; ram_hit = req_i & ~io_hit.
//  I/O offsets (addr[11:0]): 0x000 LED R/W, byte-enabled; 0x004 switches RO, zero-extended synced value;
//   0x008 cycle counter (see CONFIGURATION); all other offsets read 0, writes ignored.
//  I/O access: single cycle, never stalls. Reads are combinational. LED write takes effect at the next edge.
//  RAM, RAM_WAIT=0: ram_* = combinational pass-through of the request; rdata_o=ram_data_i; no stall.
//  RAM, RAM_WAIT>0, FSM IDLE/WAIT/DONE:
//   IDLE: on ram_hit, assert stallreq_o combinationally, drive ram_ce_o/we/sel/addr/data, load cnt=RAM_WAIT-1, go WAIT.
//   WAIT: hold ram_* stable and stallreq_o=1. When cnt==0, capture ram_data_i into a read register and go DONE; else cnt--.
//   DONE: stallreq_o=0, ram_ce_o=0, rdata_o=captured data. The pipeline advances at the end of this cycle.
//    Go IDLE unconditionally; req_i in DONE belongs to the finished access and is ignored.
//   A write is presented for exactly RAM_WAIT+1 cycles, one access per instruction.
//  Total RAM latency = RAM_WAIT+2 cycles, with stallreq_o high for RAM_WAIT+1 of them.
//  req_i dropping in WAIT (flush) returns the FSM to IDLE and drops stallreq_o next cycle. The write may be partial; software must not rely on it.
//  Switches: SYNC_STAGES-flop synchroniser, no debounce.
//  sel_i=0 on a write: no byte is modified; on RAM the access is still performed with sel=0.
// CONFIGURATION
//  DBUS_CYCLE_CNT_EN defined: 32-bit free-running counter increments every clk and wraps 0xFFFF_FFFF->0.
//   Read at 0x008; any write to 0x008 clears it to 0. When write and increment coincide, the write wins.
//  Undefined: no counter flops; 0x008 reads 0 and writes are ignored.
// STRUCTURE
//  Shared defines (defines.v): IO_BASE default, offsets `IO_LED/`IO_SW/`IO_CNT, FSM encodings `DB_IDLE/`DB_WAIT/`DB_DONE.
//  Sub-module: gpio_sync (parametrised SW_W x SYNC_STAGES synchroniser, async active-low reset).
// TESTING
//  1 Write 0xBFD0_0000 data 0x0000_00A5 sel=4'b0001 -> led_out=0x0000_00A5 next edge; stallreq_o never high.
//  2 switch_on=12'hABC held -> read 0xBFD0_0004 returns 0x0000_0ABC after SYNC_STAGES edges, 0 before.
//  3 RAM_WAIT=2, read 0x0000_0040 with RAM returning 0x1234_5678 -> stallreq_o high 3 cycles; DONE rdata_o=0x1234_5678; one access only.
//  4 RAM_WAIT=0, back-to-back RAM write then read -> no stall; ram_ce_o high both cycles with pass-through values.
//  5 rst asserted during WAIT -> stallreq_o, ram_ce_o, led_out at 0 immediately; FSM IDLE after release.
//  6 DBUS_CYCLE_CNT_EN: write 0x008, then read 5 cycles later -> 0x0000_0005; counter preset to 0xFFFF_FFFF wraps to 0.

Source files
------------

// File: rtl/dbus_bridge_pkg.sv
// Shared constants for the data-bus bridge: default MMIO base, I/O register
// offsets and the RAM access FSM encoding.
package dbus_bridge_pkg;

   localparam logic [31:0] IO_BASE_DEF = 32'hBFD0_0000;

   localparam logic [11:0] IO_LED = 12'h000;
   localparam logic [11:0] IO_SW  = 12'h004;
   localparam logic [11:0] IO_CNT = 12'h008;

   typedef enum logic [1:0] {
      DB_IDLE = 2'd0,
      DB_WAIT = 2'd1,
      DB_DONE = 2'd2
   } db_state_e;

endpackage

// File: rtl/dbus_bridge_gpio_sync.sv
// Multi-flop synchroniser for the asynchronous switch inputs (no debounce).
// The value appears on q after STAGES clock edges.
module dbus_bridge_gpio_sync #(
   parameter int W      = 12,
   parameter int STAGES = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [STAGES-1:0][W-1:0] sync_pipe;

   // shift the raw input through the synchroniser chain
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) sync_pipe <= '0;
      else      sync_pipe <= {sync_pipe[STAGES-2:0], d};
   end

   assign q = sync_pipe[STAGES-1];

endmodule

// File: rtl/dbus_bridge.sv
// Data-bus bridge: MEM stage to data RAM (with optional wait states) and a
// 4 KB MMIO window holding LEDs, switches and an optional cycle counter.
// Optional feature: define DBUS_CYCLE_CNT_EN to build the 32-bit cycle counter
// at I/O offset 0x008.
module dbus_bridge
   import dbus_bridge_pkg::*;
#(
   parameter int              DATA_W      = 32,
   parameter int              ADDR_W      = 32,
   parameter int              RAM_WAIT    = 1,
   parameter logic [31:0]     IO_BASE     = IO_BASE_DEF,
   parameter int              SW_W        = 12,
   parameter int              LED_W       = 32,
   parameter int              SYNC_STAGES = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_i,
   input  logic                we_i,
   input  logic [ADDR_W-1:0]   addr_i,
   input  logic [DATA_W/8-1:0] sel_i,
   input  logic [DATA_W-1:0]   wdata_i,
   output logic [DATA_W-1:0]   rdata_o,
   output logic                stallreq_o,
   output logic                ram_ce_o,
   output logic                ram_we_o,
   output logic [DATA_W/8-1:0] ram_sel_o,
   output logic [ADDR_W-1:0]   ram_addr_o,
   output logic [DATA_W-1:0]   ram_data_o,
   input  logic [DATA_W-1:0]   ram_data_i,
   input  logic [SW_W-1:0]     switch_on,
   output logic [LED_W-1:0]    led_out
);

   // Requests are masked while reset is held so nothing combinational leaks out.
   logic              active, io_win, io_hit, ram_hit;
   logic [11:0]       offset;
   logic [SW_W-1:0]   sw_sync;
   logic [DATA_W-1:0] io_rdata, ram_rdata;
   logic              ram_rvld;

   assign active  = req_i & rst;
   assign io_win  = (addr_i[ADDR_W-1:12] == IO_BASE[ADDR_W-1:12]);
   assign io_hit  = active & io_win;
   assign ram_hit = active & ~io_win;
   assign offset  = addr_i[11:0];

   dbus_bridge_gpio_sync #(.W(SW_W), .STAGES(SYNC_STAGES)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (switch_on),
      .q   (sw_sync)
   );

   // LED register, byte-enabled write
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) led_out <= '0;
      else if (io_hit && we_i && offset == IO_LED) begin
         for (int i = 0; i < LED_W; i++)
            if (sel_i[i/8]) led_out[i] <= wdata_i[i];
      end
   end

`ifdef DBUS_CYCLE_CNT_EN
   logic [31:0] cyc_cnt;

   // free-running counter; a write to its offset clears it and beats the increment
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) cyc_cnt <= '0;
      else if (io_hit && we_i && offset == IO_CNT) cyc_cnt <= '0;
      else cyc_cnt <= cyc_cnt + 32'd1;
   end
`endif

   // combinational MMIO read mux; unmapped offsets read zero
   always_comb begin
      io_rdata = '0;
      case (offset)
         IO_LED: io_rdata[LED_W-1:0] = led_out;
         IO_SW:  io_rdata[SW_W-1:0]  = sw_sync;
`ifdef DBUS_CYCLE_CNT_EN
         IO_CNT: io_rdata[31:0]      = cyc_cnt;
`endif
         default: io_rdata = '0;
      endcase
   end

   generate
      if (RAM_WAIT == 0) begin : g_nowait
         // single-cycle RAM: straight pass-through, never stalls
         assign stallreq_o = 1'b0;
         assign ram_ce_o   = ram_hit;
         assign ram_we_o   = ram_hit & we_i;
         assign ram_sel_o  = ram_hit ? sel_i : '0;
         assign ram_addr_o = addr_i;
         assign ram_data_o = wdata_i;
         assign ram_rdata  = ram_data_i;
         assign ram_rvld   = ram_hit;
      end else begin : g_wait
         localparam int CNT_W = (RAM_WAIT > 1) ? $clog2(RAM_WAIT) : 1;

         db_state_e           state_q, state_d;
         logic [CNT_W-1:0]    cnt_q, cnt_d;
         logic                cap;
         logic                we_q;
         logic [DATA_W/8-1:0] sel_q;
         logic [ADDR_W-1:0]   addr_q;
         logic [DATA_W-1:0]   wdata_q, rd_q;

         // FSM state register
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) state_q <= DB_IDLE;
            else      state_q <= state_d;
         end

         // wait counter, latched request (held stable in WAIT) and read capture
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               cnt_q   <= '0;
               we_q    <= 1'b0;
               sel_q   <= '0;
               addr_q  <= '0;
               wdata_q <= '0;
               rd_q    <= '0;
            end else begin
               cnt_q <= cnt_d;
               if (state_q == DB_IDLE && ram_hit) begin
                  we_q    <= we_i;
                  sel_q   <= sel_i;
                  addr_q  <= addr_i;
                  wdata_q <= wdata_i;
               end
               if (cap) rd_q <= ram_data_i;
            end
         end

         // next state and RAM-side outputs
         always_comb begin
            state_d    = state_q;
            cnt_d      = cnt_q;
            cap        = 1'b0;
            stallreq_o = 1'b0;
            ram_ce_o   = 1'b0;
            ram_we_o   = 1'b0;
            ram_sel_o  = '0;
            ram_addr_o = addr_q;
            ram_data_o = wdata_q;
            case (state_q)
               DB_IDLE: begin
                  ram_addr_o = addr_i;
                  ram_data_o = wdata_i;
                  if (ram_hit) begin
                     stallreq_o = 1'b1;
                     ram_ce_o   = 1'b1;
                     ram_we_o   = we_i;
                     ram_sel_o  = sel_i;
                     cnt_d      = CNT_W'(RAM_WAIT - 1);
                     state_d    = DB_WAIT;
                  end
               end
               DB_WAIT: begin
                  stallreq_o = 1'b1;
                  ram_ce_o   = 1'b1;
                  ram_we_o   = we_q;
                  ram_sel_o  = sel_q;
                  if (!req_i) state_d = DB_IDLE;     // flushed
                  else if (cnt_q == '0) begin
                     cap     = 1'b1;
                     state_d = DB_DONE;
                  end else cnt_d = cnt_q - CNT_W'(1);
               end
               DB_DONE: state_d = DB_IDLE;          // req_i here is the finished access
               default: state_d = DB_IDLE;
            endcase
         end

         assign ram_rdata = rd_q;
         assign ram_rvld  = (state_q == DB_DONE);
      end
   endgenerate

   // read data back to the MEM stage
   always_comb begin
      rdata_o = '0;
      if (io_hit)        rdata_o = io_rdata;
      else if (ram_rvld) rdata_o = ram_rdata;
   end

endmodule

// File: tb/tb_dbus_bridge.sv
// Bench for dbus_bridge: one instance with RAM_WAIT=2 (suffix _a) and one
// with RAM_WAIT=0 (suffix _b). Expected read/LED values go into a scoreboard
// queue when a transaction is driven and are popped when the DUT answers.
module tb_dbus_bridge;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        we;
   logic [31:0] addr, wdata;
   logic [3:0]  sel;
   logic [11:0] sw;

   logic        req_a, stall_a, ce_a, rwe_a;
   logic [3:0]  rsel_a;
   logic [31:0] rdata_a, raddr_a, rdo_a, rdi_a, led_a;
   logic        req_b, stall_b, ce_b, rwe_b;
   logic [3:0]  rsel_b;
   logic [31:0] rdata_b, raddr_b, rdo_b, rdi_b, led_b;

   int          n_chk  = 0;
   int          n_fail = 0;
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   dbus_bridge #(.RAM_WAIT(2)) u_a (
      .clk(clk), .rst(rst), .req_i(req_a), .we_i(we), .addr_i(addr), .sel_i(sel),
      .wdata_i(wdata), .rdata_o(rdata_a), .stallreq_o(stall_a), .ram_ce_o(ce_a),
      .ram_we_o(rwe_a), .ram_sel_o(rsel_a), .ram_addr_o(raddr_a), .ram_data_o(rdo_a),
      .ram_data_i(rdi_a), .switch_on(sw), .led_out(led_a)
   );

   dbus_bridge #(.RAM_WAIT(0)) u_b (
      .clk(clk), .rst(rst), .req_i(req_b), .we_i(we), .addr_i(addr), .sel_i(sel),
      .wdata_i(wdata), .rdata_o(rdata_b), .stallreq_o(stall_b), .ram_ce_o(ce_b),
      .ram_we_o(rwe_b), .ram_sel_o(rsel_b), .ram_addr_o(raddr_b), .ram_data_o(rdo_b),
      .ram_data_i(rdi_b), .switch_on(sw), .led_out(led_b)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic push(input logic [31:0] e);
      exp_q.push_back(e);
   endtask

   task automatic pop_chk(input string tag, input logic [31:0] act);
      if (exp_q.size() == 0) chk({tag, "_sb_empty"}, 32'd1, 32'd0);
      else                   chk(tag, act, exp_q.pop_front());
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   // one RAM access on the wait-state instance; checks stall length, bus
   // stability during the stall, and the DONE-cycle read data for reads
   task automatic ram_a(input string tag, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s);
      int st = 0;
      int ce = 0;
      int bad = 0;
      logic done = 1'b0;
      step();
      req_a = 1'b1; we = w; addr = a; wdata = d; sel = s;
      if (!w) push(rdi_a);
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (!stall_a) begin done = 1'b1; break; end
         st++;
         if (ce_a) ce++;
         if (raddr_a !== a || rwe_a !== w || rsel_a !== s || rdo_a !== d) bad++;
      end
      chk({tag, "_timeout"}, 32'(done), 32'd1);
      chk({tag, "_stall_cyc"}, 32'(st), 32'd3);
      chk({tag, "_ce_cyc"}, 32'(ce), 32'd3);
      chk({tag, "_bus_hold"}, 32'(bad), 32'd0);
      chk({tag, "_done_ce"}, 32'(ce_a), 32'd0);
      if (!w) pop_chk({tag, "_rdata"}, rdata_a);
      step();
      req_a = 1'b0;
      @(negedge clk);
      chk({tag, "_idle_ce"}, 32'(ce_a), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      req_a = 0; req_b = 0; we = 0; addr = 0; wdata = 0; sel = 0; sw = 0;
      rdi_a = 0; rdi_b = 0;

      // reset state
      #12;
      chk("rst_led", led_a, 32'd0);
      chk("rst_stall", 32'(stall_a), 32'd0);
      chk("rst_ce", 32'(ce_a), 32'd0);
      chk("rst_rdata", rdata_a, 32'd0);
      @(negedge clk); rst = 1'b1;

      // LED writes, byte enables, sel=0 write, readback
      step();
      req_a = 1; we = 1; addr = 32'hBFD0_0000; wdata = 32'h0000_00A5; sel = 4'b0001;
      push(32'h0000_00A5);
      @(negedge clk); chk("t1_stall", 32'(stall_a), 32'd0);
      step(); pop_chk("t1_led", led_a);
      wdata = 32'hFFFF_FFFF; sel = 4'b0100; push(32'h00FF_00A5);
      step(); pop_chk("t1_led_be", led_a);
      wdata = 32'h1234_5678; sel = 4'b0000; push(32'h00FF_00A5);
      step(); pop_chk("t1_led_sel0", led_a);
      we = 0; sel = 4'hF; push(32'h00FF_00A5);
      @(negedge clk); pop_chk("t1_led_rd", rdata_a);

      // switch synchroniser latency
      step();
      sw = 12'hABC; addr = 32'hBFD0_0004; we = 0;
      push(32'd0); @(negedge clk); pop_chk("t2_sw_e0", rdata_a);
      push(32'd0); step(); @(negedge clk); pop_chk("t2_sw_e1", rdata_a);
      push(32'h0000_0ABC); step(); @(negedge clk); pop_chk("t2_sw_e2", rdata_a);
      addr = 32'hBFD0_0010; push(32'd0); #1; @(negedge clk); pop_chk("t2_unmapped", rdata_a);
`ifndef DBUS_CYCLE_CNT_EN
      addr = 32'hBFD0_0008; push(32'd0); #1; @(negedge clk); pop_chk("t2_cnt_off", rdata_a);
`endif
      step(); req_a = 0;

      // wait-state RAM read and write
      rdi_a = 32'h1234_5678;
      ram_a("t3_rd", 1'b0, 32'h0000_0040, 32'h0, 4'hF);
      ram_a("t3_wr", 1'b1, 32'h0000_0044, 32'h0000_55AA, 4'b0011);

      // flush in WAIT
      step(); req_a = 1; we = 0; addr = 32'h0000_0048; sel = 4'hF;
      step(); req_a = 0;
      @(negedge clk); chk("t3_flush_wait", 32'(stall_a), 32'd1);
      @(negedge clk); chk("t3_flush_idle", 32'(stall_a), 32'd0);
      chk("t3_flush_ce", 32'(ce_a), 32'd0);

      // zero-wait RAM: write then read back to back
      step();
      req_b = 1; we = 1; addr = 32'h0000_0080; wdata = 32'hDEAD_BEEF; sel = 4'hF;
      @(negedge clk);
      chk("t4_w_stall", 32'(stall_b), 32'd0);
      chk("t4_w_ce", 32'(ce_b), 32'd1);
      chk("t4_w_we", 32'(rwe_b), 32'd1);
      chk("t4_w_addr", raddr_b, 32'h0000_0080);
      chk("t4_w_data", rdo_b, 32'hDEAD_BEEF);
      step();
      we = 0; addr = 32'h0000_0084; rdi_b = 32'hCAFE_F00D; push(32'hCAFE_F00D);
      @(negedge clk);
      chk("t4_r_stall", 32'(stall_b), 32'd0);
      chk("t4_r_ce", 32'(ce_b), 32'd1);
      chk("t4_r_we", 32'(rwe_b), 32'd0);
      chk("t4_r_addr", raddr_b, 32'h0000_0084);
      pop_chk("t4_r_rdata", rdata_b);
      step(); req_b = 0;

      // reset in WAIT
      req_a = 1; we = 0; addr = 32'h0000_0040;
      @(posedge clk); #2;
      rst = 1'b0; #1;
      chk("t5_stall", 32'(stall_a), 32'd0);
      chk("t5_ce", 32'(ce_a), 32'd0);
      chk("t5_led", led_a, 32'd0);
      req_a = 0;
      @(negedge clk); rst = 1'b1;
      rdi_a = 32'h0BAD_F00D;
      ram_a("t5_after", 1'b0, 32'h0000_0040, 32'h0, 4'hF);

`ifdef DBUS_CYCLE_CNT_EN
      // counter clear and count
      step(); req_a = 1; we = 1; addr = 32'hBFD0_0008; wdata = 32'hFFFF_FFFF;
      step(); req_a = 0; we = 0;
      repeat (5) @(posedge clk);
      #1; req_a = 1; push(32'd5);
      @(negedge clk); pop_chk("t6_cnt", rdata_a);
      step(); req_a = 0;
`endif

      chk("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
